// File: rtl/divide16by8_signed_pkg.sv
// Shared widths, state encoding and small two's-complement helpers
// for the sequential 16/8 signed divider.
package divide16by8_signed_pkg;

    localparam int DW        = 16;
    localparam int VW        = 8;
    localparam int REM_W     = 17;
    localparam int DIV_STEPS = 16;
    localparam int CNT_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ABS  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // -32768 maps to 16'h8000, which is the correct unsigned magnitude.
    function automatic logic [DW-1:0] mag_dw(input logic [DW-1:0] v);
        return v[DW-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [VW-1:0] mag_vw(input logic [VW-1:0] v);
        return v[VW-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [VW-1:0] neg_vw(input logic [VW-1:0] v);
        return ~v + 1'b1;
    endfunction

endpackage

// File: rtl/divide16by8_signed_if.sv
// Request/response bundle of the divider: operands plus start/busy/done
// handshake and the signed results.
interface divide16by8_signed_if;
    import divide16by8_signed_pkg::*;

    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [VW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, overflow
    );

endinterface

// File: rtl/divide16by8_signed_div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, trial
// subtract the divisor magnitude, keep or restore.
module div_restore_step
    import divide16by8_signed_pkg::*;
(
    input  logic [REM_W-1:0] rem_in,
    input  logic             dvd_msb,
    input  logic [VW-1:0]    divisor_mag,
    output logic [REM_W-1:0] rem_out,
    output logic             qbit
);

    logic [REM_W:0] shifted;
    logic [REM_W:0] trial;

    // The partial remainder stays below the divisor magnitude, so the top
    // bit of the widened difference acts as the borrow/sign flag.
    always_comb begin
        shifted = {rem_in, dvd_msb};
        trial   = shifted - {{(REM_W + 1 - VW){1'b0}}, divisor_mag};
        qbit    = ~trial[REM_W];
        rem_out = qbit ? trial[REM_W-1:0] : shifted[REM_W-1:0];
    end

endmodule

// File: rtl/divide16by8_signed.sv
// Sequential signed 16/8 divider: magnitude restoring division followed by a
// sign fix-up, truncating toward zero, with a start/busy/done handshake.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; results from the last operation held
// ABS     | take operand magnitudes, record signs and divide-by-zero
// DIV     | 16 restoring steps, counter runs 15..0
// FIX     | range check, apply signs, load result registers
// DONE    | done pulse for one cycle, then back to IDLE
module divide16by8_signed
    import divide16by8_signed_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    divide16by8_signed_if.slave     bus
);

    state_t state;
    state_t state_nxt;

    logic [DW-1:0]    op_dividend;
    logic [VW-1:0]    op_divisor;
    logic [DW-1:0]    dvd;
    logic [VW-1:0]    dsr_mag;
    logic [REM_W-1:0] rem;
    logic [CNT_W-1:0] cnt;
    logic             sign_q;
    logic             sign_r;
    logic             div0;

    logic [REM_W-1:0] rem_step;
    logic             qbit;

    logic [VW-1:0]    quotient_r;
    logic [VW-1:0]    remainder_r;
    logic             overflow_r;
    logic             fix_ovf;
    logic             busy_c;
    logic             done_c;
    logic             rem_hi_unused;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b1;
        done_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (bus.start) begin
                    state_nxt = ST_ABS;
                end
            end
            ST_ABS:  state_nxt = ST_DIV;
            ST_DIV: begin
                if (cnt == '0) begin
                    state_nxt = ST_FIX;
                end
            end
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: begin
                done_c    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy_c    = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    div_restore_step u_step (
        .rem_in      (rem),
        .dvd_msb     (dvd[DW-1]),
        .divisor_mag (dsr_mag),
        .rem_out     (rem_step),
        .qbit        (qbit)
    );

    // After DIV, dvd holds the magnitude quotient and rem the magnitude
    // remainder; a negative quotient may reach -128, a positive one only 127.
    assign fix_ovf = div0
                   | (!sign_q && (dvd > DW'(127)))
                   | ( sign_q && (dvd > DW'(128)));

    // The remainder magnitude is always below 128, so only its low byte matters.
    assign rem_hi_unused = |rem[REM_W-1:VW];

    always_ff @(posedge clk) begin
        if (reset) begin
            op_dividend <= '0;
            op_divisor  <= '0;
            dvd         <= '0;
            dsr_mag     <= '0;
            rem         <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            div0        <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            overflow_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_dividend <= bus.dividend;
                        op_divisor  <= bus.divisor;
                        quotient_r  <= '0;
                        remainder_r <= '0;
                        overflow_r  <= 1'b0;
                    end
                end
                ST_ABS: begin
                    dvd     <= mag_dw(op_dividend);
                    dsr_mag <= mag_vw(op_divisor);
                    sign_q  <= op_dividend[DW-1] ^ op_divisor[VW-1];
                    sign_r  <= op_dividend[DW-1];
                    div0    <= (op_divisor == '0);
                    rem     <= '0;
                    cnt     <= CNT_W'(DIV_STEPS - 1);
                end
                ST_DIV: begin
                    rem <= rem_step;
                    dvd <= {dvd[DW-2:0], qbit};
                    cnt <= cnt - 1'b1;
                end
                ST_FIX: begin
                    overflow_r <= fix_ovf;
                    if (fix_ovf) begin
                        quotient_r  <= '0;
                        remainder_r <= '0;
                    end else begin
                        quotient_r  <= sign_q ? neg_vw(dvd[VW-1:0]) : dvd[VW-1:0];
                        remainder_r <= sign_r ? neg_vw(rem[VW-1:0]) : rem[VW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_divide16by8_signed.sv
// Self-checking bench for divide16by8_signed: directed vectors with literal
// expectations plus an arithmetic reference model checked every cycle.
module tb_divide16by8_signed;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    divide16by8_signed_if bus ();

    divide16by8_signed dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         a;
        int         d;
        logic [7:0] q;
        logic [7:0] r;
        logic       o;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    exp_t cur;
    exp_t last;
    int   rt;
    logic rst_seen = 1'b1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: truncating integer division, result must fit in 8 signed bits.
    function automatic exp_t model(input int a, input int d);
        exp_t e;
        int   qi;
        int   ri;
        e.a = a;
        e.d = d;
        e.q = 8'h00;
        e.r = 8'h00;
        e.o = 1'b1;
        if (d != 0) begin
            qi = a / d;
            ri = a % d;
            if (qi <= 127 && qi >= -128) begin
                e.q = 8'(qi);
                e.r = 8'(ri);
                e.o = 1'b0;
            end
        end
        return e;
    endfunction

    always @(posedge clk) rst_seen <= reset;

    always @(negedge clk) begin
        if (rst_seen) begin
            exp_q.delete();
            last.q = 8'h00;
            last.r = 8'h00;
            last.o = 1'b0;
            check("reset_busy", int'(bus.busy), 0);
            check("reset_done", int'(bus.done), 0);
            check("reset_q", int'(bus.quotient), 0);
            check("reset_r", int'(bus.remainder), 0);
            check("reset_ovf", int'(bus.overflow), 0);
        end else if (bus.done) begin
            check("done_with_busy", int'(bus.busy), 1);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                cur = exp_q.pop_front();
                check("model_q", int'(bus.quotient), int'(cur.q));
                check("model_r", int'(bus.remainder), int'(cur.r));
                check("model_ovf", int'(bus.overflow), int'(cur.o));
                if (!cur.o) begin
                    rt = $signed(bus.quotient) * cur.d + $signed(bus.remainder);
                    check("round_trip", rt, cur.a);
                end
                last = cur;
            end
        end else if (bus.busy) begin
            check("cleared_q", int'(bus.quotient), 0);
            check("cleared_r", int'(bus.remainder), 0);
            check("cleared_ovf", int'(bus.overflow), 0);
        end else begin
            check("hold_q", int'(bus.quotient), int'(last.q));
            check("hold_r", int'(bus.remainder), int'(last.r));
            check("hold_ovf", int'(bus.overflow), int'(last.o));
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge with it idle.
    task automatic run_op(input int a, input int d, input int pulse_at,
                          output logic [7:0] q, output logic [7:0] r, output logic o,
                          output int done_cyc, output int busy_cyc, output int ndone);
        int i;
        q = 8'h00; r = 8'h00; o = 1'b0;
        done_cyc = 0; busy_cyc = 0; ndone = 0;
        bus.start    = 1'b1;
        bus.dividend = 16'(a);
        bus.divisor  = 8'(d);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        exp_q.push_back(model(a, d));
        i = 0;
        while (i < 30) begin
            @(negedge clk);
            i++;
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                ndone++;
                if (done_cyc == 0) done_cyc = i;
                q = bus.quotient;
                r = bus.remainder;
                o = bus.overflow;
            end
            if (pulse_at != 0 && i == pulse_at) begin
                bus.start    = 1'b1;
                bus.dividend = 16'hFE0C;
                bus.divisor  = 8'h03;
            end else begin
                bus.start = 1'b0;
            end
            if (done_cyc != 0 && !bus.busy) break;
        end
        bus.start = 1'b0;
        if (done_cyc == 0) check("done_timeout", i, 19);
    endtask

    task automatic directed(input string name, input int a, input int d, input int pulse_at,
                            input logic [7:0] eq, input logic [7:0] er, input logic eo);
        logic [7:0] q, r;
        logic o;
        int dc, bc, nd;
        run_op(a, d, pulse_at, q, r, o, dc, bc, nd);
        check({name, "_q"}, int'(q), int'(eq));
        check({name, "_r"}, int'(r), int'(er));
        check({name, "_ovf"}, int'(o), int'(eo));
        check({name, "_latency"}, dc, 19);
        check({name, "_busy_cycles"}, bc, 19);
        check({name, "_done_count"}, nd, 1);
    endtask

    initial begin
        exp_t m;
        logic [7:0] q, r;
        logic o;
        int dc, bc, nd;
        int dvd_list[8];
        int dsr_list[4];

        bus.start    = 1'b0;
        bus.dividend = 16'h0000;
        bus.divisor  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        m = model(100, 7);
        check("model_pin_100_7_q", int'(m.q), 'h0E);
        check("model_pin_100_7_r", int'(m.r), 'h02);
        m = model(-100, 7);
        check("model_pin_m100_7_q", int'(m.q), 'hF2);
        check("model_pin_m100_7_r", int'(m.r), 'hFE);
        m = model(16256, 127);
        check("model_pin_16256_ovf", int'(m.o), 1);
        m = model(16384, -128);
        check("model_pin_16384_q", int'(m.q), 'h80);

        directed("d_100_7",      100,    7,    0, 8'h0E, 8'h02, 1'b0);
        directed("d_m100_7",     -100,   7,    0, 8'hF2, 8'hFE, 1'b0);
        directed("d_100_m7",     100,    -7,   0, 8'hF2, 8'h02, 1'b0);
        directed("d_m100_m7",    -100,   -7,   0, 8'h0E, 8'hFE, 1'b0);
        directed("d_16384_m128", 16384,  -128, 0, 8'h80, 8'h00, 1'b0);
        directed("d_16256_127",  16256,  127,  0, 8'h00, 8'h00, 1'b1);
        directed("d_16129_127",  16129,  127,  0, 8'h7F, 8'h00, 1'b0);
        directed("d_m32768_m128",-32768, -128, 0, 8'h00, 8'h00, 1'b1);
        directed("d_m32768_m1",  -32768, -1,   0, 8'h00, 8'h00, 1'b1);
        directed("d_1234_0",     1234,   0,    0, 8'h00, 8'h00, 1'b1);
        directed("d_midpulse",   100,    7,    6, 8'h0E, 8'h02, 1'b0);
        directed("d_donepulse",  -100,   -7,   19, 8'h0E, 8'hFE, 1'b0);

        // Reset during DIV with a simultaneous start request.
        bus.start    = 1'b1;
        bus.dividend = 16'd100;
        bus.divisor  = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        exp_q.push_back(model(100, 7));
        repeat (6) @(negedge clk);
        reset        = 1'b1;
        bus.start    = 1'b1;
        bus.dividend = 16'd55;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        check("rst_mid_busy", int'(bus.busy), 0);
        check("rst_mid_q", int'(bus.quotient), 0);
        nd = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) nd++;
        end
        check("rst_mid_no_activity", nd, 0);
        directed("d_after_reset", 100, 7, 0, 8'h0E, 8'h02, 1'b0);

        dvd_list = '{-128, -127, -65, -1, 0, 1, 64, 127};
        for (int di = 0; di < 8; di++) begin
            for (int d = -128; d <= 127; d++) begin
                if (d != 0) begin
                    run_op(dvd_list[di], d, 0, q, r, o, dc, bc, nd);
                    check("sweep_latency", dc, 19);
                    check("sweep_done_count", nd, 1);
                end
            end
        end

        dsr_list = '{-128, -3, 3, 127};
        for (int si = 0; si < 4; si++) begin
            for (int a = -128; a <= 127; a++) begin
                run_op(a, dsr_list[si], 0, q, r, o, dc, bc, nd);
                check("sweep2_done_count", nd, 1);
            end
        end

        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
